busar_d: RTL and testbench

BUSAR_D -- requirements
Module: busar_d

---
 rtl/busar_d.sv | 178 +++++++++++++++++
 tb/tb_busar_d.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/busar_d.sv
// -----------------------------------------------------------------------------
// busar_d -- three-requester round-robin bus arbiter with registered grant.
//
// Purpose
//   Grants a shared bus to one of three requesters. The grant is held while
//   its owner keeps requesting. When the owner drops its request, the grant
//   passes in the same edge to the next requester in round-robin order.
//   A 2-bit pointer names the highest-priority requester. It moves to the
//   requester after the new owner on every grant change.
//
// Ports
//   clk  in   1  clock, all state updates on the rising edge
//   rst  in   1  asynchronous reset, active low
//   r    in   3  request vector, r[k]=1 means requester k wants the bus
//   out  out  3  grant vector, decoded from the state register
//                (one-hot or all-zero)
//
// Parameters
//   MAX_HOLD     maximum consecutive grant cycles while another request is
//                pending. Legal range is 1..15. It is used only with the
//                timeout feature.
//
// Configuration
//   BUSAR_D_TIMEOUT_EN  when defined, a 4-bit hold counter forces the grant
//                       to rotate after MAX_HOLD cycles if another requester
//                       is waiting. When undefined, an owner keeps the grant
//                       until its own request drops.
// -----------------------------------------------------------------------------
module busar_d #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] r,
    output logic [2:0] out
);

    // The state encoding equals the grant vector. Any other encoding is
    // illegal and returns to IDLE.
    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] G0   = 3'b001;
    localparam logic [2:0] G1   = 3'b010;
    localparam logic [2:0] G2   = 3'b100;

    logic [2:0] state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [2:0] competitors;
    logic       force_rotate;

    // Returns the first set bit of req (one-hot), searching from index start
    // upward, modulo 3. A start value of 3 cannot occur; it searches as 0.
    function automatic logic [2:0] pick_first(input logic [2:0] req,
                                              input logic [1:0] start);
        logic [2:0] grant;
        grant = 3'b000;
        case (start)
            2'd1: begin
                if      (req[1]) grant = G1;
                else if (req[2]) grant = G2;
                else if (req[0]) grant = G0;
            end
            2'd2: begin
                if      (req[2]) grant = G2;
                else if (req[0]) grant = G0;
                else if (req[1]) grant = G1;
            end
            default: begin
                if      (req[0]) grant = G0;
                else if (req[1]) grant = G1;
                else if (req[2]) grant = G2;
            end
        endcase
        return grant;
    endfunction

    // Returns the index after the owner of grant, modulo 3. This value is
    // both the new pointer and the start of the handover search.
    function automatic logic [1:0] succ(input logic [2:0] grant);
        logic [1:0] idx;
        case (grant)
            G0:      idx = 2'd1;
            G1:      idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    assign competitors = r & ~state_q;

`ifdef BUSAR_D_TIMEOUT_EN
    // Out-of-range MAX_HOLD values are clamped so the 4-bit counter stays
    // meaningful.
    localparam int unsigned HOLD_CLAMP = (MAX_HOLD < 1)  ? 1  :
                                         (MAX_HOLD > 15) ? 15 : MAX_HOLD;
    localparam logic [3:0]  HOLD_LIMIT = 4'(HOLD_CLAMP);

    logic [3:0] hold_q, hold_d;
    logic [4:0] hold_inc;
    logic       hold_reach;

    // hold_q counts the edges the current grant has already been held.
    // When the count would reach HOLD_LIMIT on this edge, the owner has used
    // its MAX_HOLD cycles. The check is done one bit wider so that
    // HOLD_LIMIT=15 cannot wrap.
    assign hold_inc     = {1'b0, hold_q} + 5'd1;
    assign hold_reach   = (state_q != IDLE) && (hold_inc >= {1'b0, HOLD_LIMIT});
    assign force_rotate = hold_reach && (competitors != 3'b000);
`else
    // MAX_HOLD has no effect without the timeout feature.
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD != 0);
    assign force_rotate    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;

        case (state_q)
            IDLE: begin
                if (r != 3'b000) state_d = pick_first(r, ptr_q);
            end
            G0, G1, G2: begin
                // Handover ignores the owner's own bit. When the owner has
                // dropped its request, the result is the same as searching
                // all of r. A forced rotation can therefore never re-grant
                // the same owner.
                if (((r & state_q) == 3'b000) || force_rotate)
                    state_d = pick_first(competitors, succ(state_q));
            end
            default: state_d = IDLE;
        endcase

        // The pointer moves only when a new owner is granted. Falling back
        // to IDLE keeps the old pointer.
        if ((state_d != state_q) && (state_d != IDLE))
            ptr_d = succ(state_d);
    end

`ifdef BUSAR_D_TIMEOUT_EN
    always_comb begin
        hold_d = hold_q;
        if ((state_d != state_q) || (state_q == IDLE))
            hold_d = 4'd0;
        else if (hold_reach)
            hold_d = HOLD_LIMIT;   // saturate while nobody else waits
        else
            hold_d = hold_inc[3:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hold_q <= 4'd0;
        else      hold_q <= hold_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Decoding keeps out at zero for illegal encodings, so out can never
    // show more than one bit set.
    always_comb begin
        case (state_q)
            G0:      out = 3'b001;
            G1:      out = 3'b010;
            G2:      out = 3'b100;
            default: out = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_busar_d.sv
module tb_busar_d;

    logic       clk;
    logic       rst;
    logic [2:0] r;
    logic [2:0] out;

    int errors = 0;
    int checks = 0;

    busar_d #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .r   (r),
        .out (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] exp);
        checks++;
        assert (out === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, out, exp);
        end
    endtask

    // Checks that out is one-hot or zero, and zero exactly when r is zero.
    task automatic check_prop(input string tag);
        checks++;
        assert ($onehot0(out) && ((out == 3'b000) == (r == 3'b000))) else begin
            errors++;
            $error("FAIL %s: observed=%b with r=%b required onehot0 and zero iff r=000",
                   tag, out, r);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        r   = 3'b000;
        #1;
        check("reset_async", 3'b000);
        tick();
        tick();
        rst = 1'b1;
    endtask

    logic [2:0] sweep_exp [8];

    initial begin
        rst = 1'b0;
        r   = 3'b000;
        tick();
        tick();
        check("reset_state", 3'b000);
        rst = 1'b1;

        // Single requests, each held for two edges.
        r = 3'b001; tick(); check("single_r0_a", 3'b001); tick(); check("single_r0_b", 3'b001);
        r = 3'b010; tick(); check("single_r1_a", 3'b010); tick(); check("single_r1_b", 3'b010);
        r = 3'b100; tick(); check("single_r2_a", 3'b100); tick(); check("single_r2_b", 3'b100);
        r = 3'b000; tick(); check("single_idle_a", 3'b000); tick(); check("single_idle_b", 3'b000);

        // Round-robin: each owner drops its own request after one cycle.
        do_reset();
        r = 3'b111; tick(); check("rr_g0", 3'b001);
        r = 3'b110; tick(); check("rr_g1", 3'b010);
        r = 3'b101; tick(); check("rr_g2", 3'b100);
        r = 3'b011; tick(); check("rr_g0_again", 3'b001);

        // Handover from G0 to G1 in one edge, with no idle gap.
        tick();     check("handover_hold", 3'b001);
        r = 3'b010; tick(); check("handover_g1", 3'b010);

        // Reset asserted mid-G1 drops the grant at once.
        rst = 1'b0;
        #1;
        check("reset_mid_g1", 3'b000);
        tick();     check("reset_held", 3'b000);
        r = 3'b000;
        rst = 1'b1;
        tick();     check("release_idle_a", 3'b000);
        tick();     check("release_idle_b", 3'b000);

        // Timeout: r=011 held.
        do_reset();
        r = 3'b011;
        tick(); check("to_c1", 3'b001);
        tick(); check("to_c2", 3'b001);
        tick(); check("to_c3", 3'b001);
        tick(); check("to_c4", 3'b001);
        tick();
`ifdef BUSAR_D_TIMEOUT_EN
        check("to_rotate", 3'b010);
`else
        check("to_c5_keep", 3'b001);
        tick(); check("to_c6_keep", 3'b001);
        tick(); check("to_c7_keep", 3'b001);
`endif

        // Sole requester keeps the grant; counter saturates, then a competitor appears.
        do_reset();
        r = 3'b001;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("sole_owner", 3'b001);
        end
        r = 3'b011;
        tick();
`ifdef BUSAR_D_TIMEOUT_EN
        check("sat_rotate", 3'b010);
`else
        check("sat_keep", 3'b001);
`endif

        // Sweep r through 0..7, one edge each, from reset.
        do_reset();
        sweep_exp[0] = 3'b000; sweep_exp[1] = 3'b001;
        sweep_exp[2] = 3'b010; sweep_exp[3] = 3'b010;
        sweep_exp[4] = 3'b100; sweep_exp[5] = 3'b100;
        sweep_exp[6] = 3'b100; sweep_exp[7] = 3'b100;
        for (int i = 0; i < 8; i++) begin
            r = 3'(i);
            tick();
            check_prop("sweep_prop");
            check("sweep_exact", sweep_exp[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
